// File: rtl/counter_bounded.sv
// Bounded up/down counter with wrap or saturate behaviour and registered zero/max status.
// Optional sticky overflow/underflow flags are enabled by defining COUNTER_BOUNDED_STICKY_FLAGS_EN.

module counter_bounded #(
    parameter int WIDTH      = 4,
    parameter int INCR_WIDTH = 2,
    parameter int DECR_WIDTH = 2,
    parameter int MAX_VALUE  = 2**WIDTH - 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reinit,
    input  logic [WIDTH-1:0]      initial_value,
    input  logic                  incr_valid,
    input  logic [INCR_WIDTH-1:0] incr,
    input  logic                  decr_valid,
    input  logic [DECR_WIDTH-1:0] decr,
`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
    input  logic                  clr_flags,
    output logic                  ovf_sticky,
    output logic                  unf_sticky,
`endif
    output logic [WIDTH-1:0]      value,
    output logic [WIDTH-1:0]      value_next,
    output logic                  is_zero,
    output logic                  is_max,
    output logic                  overflow,
    output logic                  underflow
);

    // Two extra bits hold the sign and the carry of base + inc - dec without truncation.
    localparam int RW = WIDTH + 2;
    localparam logic [WIDTH-1:0]     MAX_V = WIDTH'(MAX_VALUE);
    localparam logic signed [RW-1:0] MAX_R = RW'(MAX_VALUE);
    localparam logic signed [RW-1:0] MOD_R = RW'(MAX_VALUE + 1);

    if ((MAX_VALUE < 1) || (MAX_VALUE > 2**WIDTH - 1) ||
        (2**INCR_WIDTH - 1 > MAX_VALUE) || (2**DECR_WIDTH - 1 > MAX_VALUE)) begin : g_bad_params
        $error("counter_bounded: illegal MAX_VALUE / step width combination");
    end

    logic [WIDTH-1:0]     value_q, value_d, load_d;
    logic                 is_zero_q, is_max_q;
    logic [WIDTH-1:0]     iv_c, base;
    logic signed [RW-1:0] base_r, inc_r, dec_r, raw, res;

    assign iv_c   = (initial_value > MAX_V) ? MAX_V : initial_value;
    assign base   = reinit ? iv_c : value_q;
    assign base_r = {2'b00, base};
    assign inc_r  = incr_valid ? RW'(incr) : '0;
    assign dec_r  = decr_valid ? RW'(decr) : '0;
    assign raw    = base_r + inc_r - dec_r;

    assign overflow  = (raw > MAX_R);
    assign underflow = raw[RW-1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        res = raw;
        if (overflow) begin
            res = (SATURATE != 0) ? MAX_R : raw - MOD_R;
        end else if (underflow) begin
            res = (SATURATE != 0) ? '0 : raw + MOD_R;
        end
    end

    assign value_d = WIDTH'(res);
    // Status flags are derived from the value being loaded so they line up with value.
    assign load_d  = rst ? iv_c : value_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples the pre-edge values regardless of statement order.
        value_q   <= load_d;
        is_zero_q <= (load_d == '0);
        is_max_q  <= (load_d == MAX_V);
    end

    assign value      = value_q;
    assign value_next = value_d;
    assign is_zero    = is_zero_q;
    assign is_max     = is_max_q;

`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic unf_sticky_q, unf_sticky_d;

    // A new event in the same cycle as clr_flags wins over the clear.
    assign ovf_sticky_d = overflow  | (ovf_sticky_q & ~clr_flags);
    assign unf_sticky_d = underflow | (unf_sticky_q & ~clr_flags);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
`endif

endmodule

// File: tb/tb_counter_bounded.sv
// Bench for counter_bounded: a wrapping and a saturating instance (MAX_VALUE=11) share stimulus.
// A reference model pushes expected register contents to a scoreboard popped after each edge.

module tb_counter_bounded;

    localparam int MAXV = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic [3:0] initial_value = '0;
    logic       incr_valid = 1'b0;
    logic [1:0] incr = '0;
    logic       decr_valid = 1'b0;
    logic [1:0] decr = '0;
    logic       clr_flags = 1'b0;

    logic [3:0] w_value, w_value_next, s_value, s_value_next;
    logic       w_is_zero, w_is_max, w_overflow, w_underflow;
    logic       s_is_zero, s_is_max, s_overflow, s_underflow;
`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
    logic       w_ovf_sticky, w_unf_sticky, s_ovf_sticky, s_unf_sticky;
`endif

    always #5 clk = ~clk;

    counter_bounded #(.WIDTH(4), .INCR_WIDTH(2), .DECR_WIDTH(2), .MAX_VALUE(MAXV), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
        .clr_flags(clr_flags), .ovf_sticky(w_ovf_sticky), .unf_sticky(w_unf_sticky),
`endif
        .value(w_value), .value_next(w_value_next), .is_zero(w_is_zero), .is_max(w_is_max),
        .overflow(w_overflow), .underflow(w_underflow)
    );

    counter_bounded #(.WIDTH(4), .INCR_WIDTH(2), .DECR_WIDTH(2), .MAX_VALUE(MAXV), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
        .incr_valid(incr_valid), .incr(incr), .decr_valid(decr_valid), .decr(decr),
`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
        .clr_flags(clr_flags), .ovf_sticky(s_ovf_sticky), .unf_sticky(s_unf_sticky),
`endif
        .value(s_value), .value_next(s_value_next), .is_zero(s_is_zero), .is_max(s_is_max),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    typedef struct {
        int w_val;
        int s_val;
        bit w_ovs;
        bit w_uns;
        bit s_ovs;
        bit s_uns;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    // Reference model state and this cycle's expected combinational results.
    int m_w = 0, m_s = 0;
    bit m_w_ovs = 0, m_w_uns = 0, m_s_ovs = 0, m_s_uns = 0;
    int exp_nw, exp_ns;
    bit exp_ow, exp_uw, exp_os, exp_us;

    function automatic void model(input int base, input int inc, input int dec, input bit sat,
                                  output int nxt, output bit ovf, output bit unf);
        int raw;
        raw = base + inc - dec;
        ovf = (raw > MAXV);
        unf = (raw < 0);
        if (sat) nxt = ovf ? MAXV : (unf ? 0 : raw);
        else     nxt = ovf ? raw - (MAXV + 1) : (unf ? raw + (MAXV + 1) : raw);
    endfunction

    task automatic drive(input bit r, input bit ri, input int iv, input bit iv_en, input int inc,
                         input bit dv, input int dec, input bit clr);
        int ivc;
        @(negedge clk);
        rst = r; reinit = ri; initial_value = 4'(iv);
        incr_valid = iv_en; incr = 2'(inc); decr_valid = dv; decr = 2'(dec); clr_flags = clr;
        ivc = (iv > MAXV) ? MAXV : iv;
        model(ri ? ivc : m_w, iv_en ? inc : 0, dv ? dec : 0, 1'b0, exp_nw, exp_ow, exp_uw);
        model(ri ? ivc : m_s, iv_en ? inc : 0, dv ? dec : 0, 1'b1, exp_ns, exp_os, exp_us);
        if (r) begin
            m_w = ivc; m_s = ivc;
            m_w_ovs = 0; m_w_uns = 0; m_s_ovs = 0; m_s_uns = 0;
        end else begin
            m_w = exp_nw; m_s = exp_ns;
            m_w_ovs = exp_ow | (m_w_ovs & !clr);
            m_w_uns = exp_uw | (m_w_uns & !clr);
            m_s_ovs = exp_os | (m_s_ovs & !clr);
            m_s_uns = exp_us | (m_s_uns & !clr);
        end
        sb.push_back('{m_w, m_s, m_w_ovs, m_w_uns, m_s_ovs, m_s_uns});
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: one entry per edge, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (w_value !== 4'(e.w_val) || w_is_zero !== (e.w_val == 0) || w_is_max !== (e.w_val == MAXV)) begin
                bad++;
                $display("FAIL sb_wrap t=%0t got value=%0d z=%b m=%b exp value=%0d", $time, w_value, w_is_zero, w_is_max, e.w_val);
            end
            total++;
            if (s_value !== 4'(e.s_val) || s_is_zero !== (e.s_val == 0) || s_is_max !== (e.s_val == MAXV)) begin
                bad++;
                $display("FAIL sb_sat t=%0t got value=%0d z=%b m=%b exp value=%0d", $time, s_value, s_is_zero, s_is_max, e.s_val);
            end
`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
            total++;
            if ({w_ovf_sticky, w_unf_sticky, s_ovf_sticky, s_unf_sticky} !== {e.w_ovs, e.w_uns, e.s_ovs, e.s_uns}) begin
                bad++;
                $display("FAIL sb_sticky t=%0t got=%b%b%b%b exp=%b%b%b%b", $time, w_ovf_sticky, w_unf_sticky,
                         s_ovf_sticky, s_unf_sticky, e.w_ovs, e.w_uns, e.s_ovs, e.s_uns);
            end
`endif
        end
    end

    task automatic test_reset();
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        after_edge();
        total++;
        if (w_value !== 4'd5 || w_is_zero !== 1'b0 || w_is_max !== 1'b0) begin
            bad++;
            $display("FAIL reset_load got value=%0d z=%b m=%b exp value=5 z=0 m=0", w_value, w_is_zero, w_is_max);
        end
        drive(1, 0, 14, 0, 0, 0, 0, 0);
        after_edge();
        total++;
        if (w_value !== 4'd11 || w_is_max !== 1'b1 || s_value !== 4'd11) begin
            bad++;
            $display("FAIL reset_clamp got w=%0d m=%b s=%0d exp 11 m=1 s=11", w_value, w_is_max, s_value);
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 10, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 0, 0);
        #1;
        total++;
        if (w_value_next !== 4'd1 || w_overflow !== 1'b1 || w_underflow !== 1'b0) begin
            bad++;
            $display("FAIL wrap_ovf got next=%0d ovf=%b unf=%b exp next=1 ovf=1 unf=0", w_value_next, w_overflow, w_underflow);
        end
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 0);
        #1;
        total++;
        if (w_value_next !== 4'd10 || w_underflow !== 1'b1 || w_overflow !== 1'b0) begin
            bad++;
            $display("FAIL wrap_unf got next=%0d ovf=%b unf=%b exp next=10 ovf=0 unf=1", w_value_next, w_overflow, w_underflow);
        end
    endtask

    task automatic test_saturate();
        drive(0, 1, 10, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 0, 0);
        #1;
        total++;
        if (s_value_next !== 4'd11 || s_overflow !== 1'b1) begin
            bad++;
            $display("FAIL sat_ovf got next=%0d ovf=%b exp next=11 ovf=1", s_value_next, s_overflow);
        end
        after_edge();
        total++;
        if (s_value !== 4'd11 || s_is_max !== 1'b1) begin
            bad++;
            $display("FAIL sat_max got value=%0d m=%b exp 11 m=1", s_value, s_is_max);
        end
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 0);
        #1;
        total++;
        if (s_value_next !== 4'd0 || s_underflow !== 1'b1) begin
            bad++;
            $display("FAIL sat_unf got next=%0d unf=%b exp next=0 unf=1", s_value_next, s_underflow);
        end
        after_edge();
        total++;
        if (s_value !== 4'd0 || s_is_zero !== 1'b1) begin
            bad++;
            $display("FAIL sat_zero got value=%0d z=%b exp 0 z=1", s_value, s_is_zero);
        end
    endtask

    task automatic test_simultaneous_reinit();
        drive(0, 1, 6, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 1, 2, 0);
        #1;
        total++;
        if (w_value_next !== 4'd7 || w_overflow !== 1'b0 || w_underflow !== 1'b0) begin
            bad++;
            $display("FAIL simul_net got next=%0d ovf=%b unf=%b exp 7 0 0", w_value_next, w_overflow, w_underflow);
        end
        drive(0, 1, 2, 1, 1, 0, 0, 0);
        after_edge();
        total++;
        if (w_value !== 4'd3 || s_value !== 4'd3) begin
            bad++;
            $display("FAIL reinit_step got w=%0d s=%0d exp 3", w_value, s_value);
        end
        drive(0, 0, 0, 0, 3, 0, 0, 0);
        #1;
        total++;
        if (w_value_next !== 4'd3 || w_overflow !== 1'b0 || w_underflow !== 1'b0) begin
            bad++;
            $display("FAIL hold got next=%0d ovf=%b unf=%b exp 3 0 0", w_value_next, w_overflow, w_underflow);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 7, 0, 0, 0, 0, 0);
        drive(1, 0, 4, 1, 3, 0, 0, 0);
        after_edge();
        total++;
        if (w_value !== 4'd4 || s_value !== 4'd4) begin
            bad++;
            $display("FAIL reset_mid got w=%0d s=%0d exp 4", w_value, s_value);
        end
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        after_edge();
        total++;
        if (w_value !== 4'd5) begin
            bad++;
            $display("FAIL reset_resume got %0d exp 5", w_value);
        end
    endtask

`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
    task automatic test_sticky();
        drive(1, 0, 10, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 0, 0);
        after_edge();
        total++;
        if (w_ovf_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set got %b exp 1", w_ovf_sticky);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        after_edge();
        total++;
        if (w_ovf_sticky !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clr got %b exp 0", w_ovf_sticky);
        end
        drive(0, 1, 10, 1, 3, 0, 0, 1);
        after_edge();
        total++;
        if (w_ovf_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set_wins got %b exp 1", w_ovf_sticky);
        end
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        after_edge();
        total++;
        if (w_ovf_sticky !== 1'b0 || w_unf_sticky !== 1'b0) begin
            bad++;
            $display("FAIL sticky_rst got ovf=%b unf=%b exp 0 0", w_ovf_sticky, w_unf_sticky);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            bit r;
            r = ($urandom_range(0, 15) == 0);
            drive(r, $urandom_range(0, 7) == 0, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5) == 0);
            #1;
            if (!r) begin
                total++;
                if (w_value_next !== 4'(exp_nw) || w_overflow !== exp_ow || w_underflow !== exp_uw) begin
                    bad++;
                    $display("FAIL rand_wrap i=%0d got next=%0d o=%b u=%b exp %0d %b %b", i, w_value_next,
                             w_overflow, w_underflow, exp_nw, exp_ow, exp_uw);
                end
                total++;
                if (s_value_next !== 4'(exp_ns) || s_overflow !== exp_os || s_underflow !== exp_us) begin
                    bad++;
                    $display("FAIL rand_sat i=%0d got next=%0d o=%b u=%b exp %0d %b %b", i, s_value_next,
                             s_overflow, s_underflow, exp_ns, exp_os, exp_us);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_simultaneous_reinit();
        test_reset_mid();
`ifdef COUNTER_BOUNDED_STICKY_FLAGS_EN
        test_sticky();
`endif
        test_random();
        after_edge();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got %0d entries left exp 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
